hazard_ctrl: RTL and testbench

- Pipeline hazard controller for the 5-stage MIPS core (F/D/E/M/W).
- Consumes the D-stage address/timing tuple (ra1, ra2, wa, Tuse, res class) from the instruction decoder.
- Carries each issued instruction's (wa, Tnew, rs, rt) through E/M/W shadow registers, and generates D-stage stall plus D/E/M forwarding selects.
- Also sequences the multiply/divide unit's busy window, so HI/LO users stall while an md op is in flight.

---
 rtl/hazard_ctrl_pkg.sv | 68 ++++++
 rtl/hazard_ctrl_if.sv | 37 +++
 rtl/hazard_ctrl_md_timer.sv | 32 +++
 rtl/hazard_ctrl.sv | 89 ++++++++
 tb/tb_hazard_ctrl.sv | 353 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hazard_ctrl_pkg.sv
// Shared codes for the MIPS hazard controller: result classes, Tuse values,
// forwarding selects, the shadow-stage record and small compare helpers.
package hazard_ctrl_pkg;

  localparam int MULT_CYC_DEF = 5;
  localparam int DIV_CYC_DEF  = 10;

  typedef enum logic [2:0] {
    RES_ALU = 3'd0,
    RES_DM  = 3'd1,
    RES_PC  = 3'd2,
    RES_NW  = 3'd3
  } res_e;

  typedef enum logic [1:0] {
    TUSE_D    = 2'd0,
    TUSE_E    = 2'd1,
    TUSE_M    = 2'd2,
    TUSE_NONE = 2'd3
  } tuse_e;

  typedef enum logic [1:0] {
    FWD_RF = 2'd0,
    FWD_M  = 2'd1,
    FWD_W  = 2'd2,
    FWD_E  = 2'd3
  } fwd_e;

  typedef struct packed {
    logic [4:0] wa;
    logic [1:0] tnew;
    logic [4:0] rs;
    logic [4:0] rt;
  } stage_t;

  typedef struct packed {
    stage_t e;
    logic   e_md;
    logic   e_div;
    stage_t m;
    stage_t w;
  } shadow_t;

  function automatic logic [1:0] tnew_of(logic [2:0] res);
    case (res)
      RES_ALU: return 2'd1;
      RES_DM:  return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  function automatic logic [1:0] tnew_dec(logic [1:0] t);
    return (t == 2'd0) ? 2'd0 : t - 2'd1;
  endfunction

  // A stage can supply a value only once its result exists (tnew == 0).
  function automatic logic fwd_hit(stage_t s, logic [4:0] addr);
    return (addr != 5'd0) && (s.wa == addr) && (s.tnew == 2'd0);
  endfunction

  function automatic logic src_hazard(logic [4:0] addr, logic [1:0] tuse,
                                      stage_t e, stage_t m);
    return (tuse != TUSE_NONE) && (addr != 5'd0) &&
           (((e.wa == addr) && (e.tnew > tuse)) ||
            ((m.wa == addr) && (m.tnew > tuse)));
  endfunction

endpackage

// File: rtl/hazard_ctrl_if.sv
// Decoder <-> hazard controller bundle: D-stage tuple in, stall/forwarding out.
// The D tuple is valid every cycle; while stall is high the decoder holds the
// same tuple and E receives a bubble, so stall acts as the inverse of ready.
interface hazard_ctrl_if;
  import hazard_ctrl_pkg::*;

  logic [4:0] d_ra1;
  logic [4:0] d_ra2;
  logic [4:0] d_wa;
  logic [1:0] d_tuse_rs;
  logic [1:0] d_tuse_rt;
  logic [2:0] d_res;
  logic       d_md_start;
  logic       d_md_div;
  logic       d_md_use;

  logic       stall;
  logic [1:0] fwd_d_rs;
  logic [1:0] fwd_d_rt;
  logic [1:0] fwd_e_rs;
  logic [1:0] fwd_e_rt;
  logic       fwd_m_rt;
  logic       md_busy;

  modport master (
    output d_ra1, d_ra2, d_wa, d_tuse_rs, d_tuse_rt, d_res,
           d_md_start, d_md_div, d_md_use,
    input  stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );

  modport slave (
    input  d_ra1, d_ra2, d_wa, d_tuse_rs, d_tuse_rt, d_res,
           d_md_start, d_md_div, d_md_use,
    output stall, fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt, fwd_m_rt, md_busy
  );

endinterface

// File: rtl/hazard_ctrl_md_timer.sv
// Multiply/divide busy window: high while an md op sits in E and for the
// configured number of cycles after it leaves.
module hazard_ctrl_md_timer
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic e_md,
  input  logic e_div,
  output logic md_busy
);

  localparam int CNT_W = $clog2(((DIV_CYC > MULT_CYC) ? DIV_CYC : MULT_CYC) + 1);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (e_md) begin
      cnt <= e_div ? CNT_W'(DIV_CYC) : CNT_W'(MULT_CYC);
    end else if (cnt != '0) begin
      cnt <= cnt - CNT_W'(1);
    end
  end

  assign md_busy = e_md | (cnt != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage MIPS core: E/M/W shadow registers,
// D-stage stall and D/E/M forwarding selects, plus the md busy window.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int MULT_CYC = MULT_CYC_DEF,
  parameter int DIV_CYC  = DIV_CYC_DEF
) (
  input  logic               clk,
  input  logic               reset,
  hazard_ctrl_if.slave       hif,
  output shadow_t            dbg
);

  stage_t e_q, m_q, w_q;
  logic   e_md_q, e_div_q;
  logic   stall, md_busy;

  hazard_ctrl_md_timer #(
    .MULT_CYC (MULT_CYC),
    .DIV_CYC  (DIV_CYC)
  ) u_md_timer (
    .clk     (clk),
    .reset   (reset),
    .e_md    (e_md_q),
    .e_div   (e_div_q),
    .md_busy (md_busy)
  );

  assign stall = src_hazard(hif.d_ra1, hif.d_tuse_rs, e_q, m_q) ||
                 src_hazard(hif.d_ra2, hif.d_tuse_rt, e_q, m_q) ||
                 (hif.d_md_use && md_busy);

  // M and W keep advancing during a stall; only E swallows a bubble.
  always_ff @(posedge clk) begin
    if (reset) begin
      e_q     <= '0;
      e_md_q  <= 1'b0;
      e_div_q <= 1'b0;
      m_q     <= '0;
      w_q     <= '0;
    end else begin
      if (stall) begin
        e_q     <= '0;
        e_md_q  <= 1'b0;
        e_div_q <= 1'b0;
      end else begin
        e_q.wa   <= (hif.d_res == RES_NW) ? 5'd0 : hif.d_wa;
        e_q.tnew <= tnew_of(hif.d_res);
        e_q.rs   <= hif.d_ra1;
        e_q.rt   <= hif.d_ra2;
        e_md_q   <= hif.d_md_start;
        e_div_q  <= hif.d_md_start & hif.d_md_div;
      end
      m_q.wa   <= e_q.wa;
      m_q.tnew <= tnew_dec(e_q.tnew);
      m_q.rs   <= e_q.rs;
      m_q.rt   <= e_q.rt;
      w_q.wa   <= m_q.wa;
      w_q.tnew <= tnew_dec(m_q.tnew);
      w_q.rs   <= m_q.rs;
      w_q.rt   <= m_q.rt;
    end
  end

  always_comb begin
    hif.fwd_d_rs = FWD_RF;
    hif.fwd_d_rt = FWD_RF;
    hif.fwd_e_rs = FWD_RF;
    hif.fwd_e_rt = FWD_RF;
    if      (fwd_hit(e_q, hif.d_ra1)) hif.fwd_d_rs = FWD_E;
    else if (fwd_hit(m_q, hif.d_ra1)) hif.fwd_d_rs = FWD_M;
    else if (fwd_hit(w_q, hif.d_ra1)) hif.fwd_d_rs = FWD_W;
    if      (fwd_hit(e_q, hif.d_ra2)) hif.fwd_d_rt = FWD_E;
    else if (fwd_hit(m_q, hif.d_ra2)) hif.fwd_d_rt = FWD_M;
    else if (fwd_hit(w_q, hif.d_ra2)) hif.fwd_d_rt = FWD_W;
    if      (fwd_hit(m_q, e_q.rs)) hif.fwd_e_rs = FWD_M;
    else if (fwd_hit(w_q, e_q.rs)) hif.fwd_e_rs = FWD_W;
    if      (fwd_hit(m_q, e_q.rt)) hif.fwd_e_rt = FWD_M;
    else if (fwd_hit(w_q, e_q.rt)) hif.fwd_e_rt = FWD_W;
  end

  assign hif.fwd_m_rt = fwd_hit(w_q, m_q.rt);
  assign hif.stall    = stall;
  assign hif.md_busy  = md_busy;

  assign dbg = '{e: e_q, e_md: e_md_q, e_div: e_div_q, m: m_q, w: w_q};

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed pipeline scenarios plus randomized traffic
// checked against an age-based model of the instructions in flight.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;

  localparam int MULT_N = 5;
  localparam int DIV_N  = 10;

  logic    clk = 1'b0;
  logic    reset = 1'b1;
  shadow_t dbg;

  hazard_ctrl_if hif();

  hazard_ctrl #(.MULT_CYC(MULT_N), .DIV_CYC(DIV_N)) dut (
    .clk   (clk),
    .reset (reset),
    .hif   (hif),
    .dbg   (dbg)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0] ra1, ra2, wa;
    logic [1:0] tuse_rs, tuse_rt;
    logic [2:0] res;
    logic       md_start, md_div, md_use;
  } instr_t;

  // One issued instruction; its age in E/M/W is its index in the flight queue.
  typedef struct {
    logic [4:0] wa, rs, rt;
    int         tnew0;
    bit         md, div;
  } flight_t;

  typedef struct {
    logic       stall, md_busy, fwd_m_rt;
    logic [1:0] fwd_d_rs, fwd_d_rt, fwd_e_rs, fwd_e_rt;
  } exp_t;

  flight_t flight[$];
  int      cyc;
  int      md_until;
  int      checks = 0;
  int      errors = 0;
  instr_t  cur;

  function automatic instr_t mk(int ra1, int ra2, int wa, int tr, int tt, int res,
                                int ms, int md, int mu);
    instr_t d;
    d.ra1 = 5'(ra1); d.ra2 = 5'(ra2); d.wa = 5'(wa);
    d.tuse_rs = 2'(tr); d.tuse_rt = 2'(tt); d.res = 3'(res);
    d.md_start = 1'(ms); d.md_div = 1'(md); d.md_use = 1'(mu);
    return d;
  endfunction

  function automatic instr_t nop();
    return mk(0, 0, 0, 3, 3, 3, 0, 0, 0);
  endfunction

  function automatic flight_t blank();
    flight_t f;
    f.wa = '0; f.rs = '0; f.rt = '0; f.tnew0 = 0; f.md = 0; f.div = 0;
    return f;
  endfunction

  function automatic void model_clear();
    flight.delete();
    repeat (3) flight.push_back(blank());
    md_until = -1;
  endfunction

  function automatic int remaining(int age);
    return (flight[age].tnew0 > age) ? flight[age].tnew0 - age : 0;
  endfunction

  function automatic bit ready_at(int age, logic [4:0] a);
    return (a != 0) && (flight[age].wa == a) && (remaining(age) == 0);
  endfunction

  function automatic bit blocks(logic [4:0] a, logic [1:0] tuse);
    if (tuse == 2'd3 || a == 0) return 0;
    for (int age = 0; age < 2; age++)
      if (flight[age].wa == a && remaining(age) > int'(tuse)) return 1;
    return 0;
  endfunction

  function automatic logic [1:0] d_src(logic [4:0] a);
    if (ready_at(0, a)) return 2'd3;
    if (ready_at(1, a)) return 2'd1;
    if (ready_at(2, a)) return 2'd2;
    return 2'd0;
  endfunction

  // Forward select for a consumer at age c: the code is the producer's distance.
  function automatic logic [1:0] older_src(logic [4:0] a, int c);
    for (int age = c + 1; age <= 2; age++)
      if (ready_at(age, a)) return 2'(age - c);
    return 2'd0;
  endfunction

  function automatic bit busy_now();
    return flight[0].md || (cyc <= md_until);
  endfunction

  function automatic exp_t eval(instr_t d);
    exp_t e;
    e.md_busy  = busy_now();
    e.stall    = blocks(d.ra1, d.tuse_rs) || blocks(d.ra2, d.tuse_rt) ||
                 (d.md_use && e.md_busy);
    e.fwd_d_rs = d_src(d.ra1);
    e.fwd_d_rt = d_src(d.ra2);
    e.fwd_e_rs = older_src(flight[0].rs, 0);
    e.fwd_e_rt = older_src(flight[0].rt, 0);
    e.fwd_m_rt = (older_src(flight[1].rt, 1) == 2'd1);
    return e;
  endfunction

  function automatic void model_advance(instr_t d, logic rst);
    flight_t f;
    exp_t    e;
    if (rst) begin
      model_clear();
    end else begin
      e = eval(d);
      if (flight[0].md) md_until = cyc + (flight[0].div ? DIV_N : MULT_N);
      f = blank();
      if (!e.stall) begin
        f.wa    = (d.res == 3'd3) ? 5'd0 : d.wa;
        f.tnew0 = (d.res == 3'd0) ? 1 : (d.res == 3'd1) ? 2 : 0;
        f.rs    = d.ra1;
        f.rt    = d.ra2;
        f.md    = d.md_start;
        f.div   = d.md_start && d.md_div;
      end
      flight.push_front(f);
      void'(flight.pop_back());
    end
    cyc++;
  endfunction

  task automatic drive(instr_t d);
    cur = d;
    hif.d_ra1 = d.ra1; hif.d_ra2 = d.ra2; hif.d_wa = d.wa;
    hif.d_tuse_rs = d.tuse_rs; hif.d_tuse_rt = d.tuse_rt; hif.d_res = d.res;
    hif.d_md_start = d.md_start; hif.d_md_div = d.md_div; hif.d_md_use = d.md_use;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic step();
    model_advance(cur, reset);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(nop());
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", hif.stall); end
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL rst_md_busy: got %0b want 0", hif.md_busy); end
    checks++; if (hif.fwd_d_rs !== 2'd0) begin errors++; $display("FAIL rst_fwd_d_rs: got %0d want 0", hif.fwd_d_rs); end
    checks++; if (hif.fwd_d_rt !== 2'd0) begin errors++; $display("FAIL rst_fwd_d_rt: got %0d want 0", hif.fwd_d_rt); end
    checks++; if (hif.fwd_e_rs !== 2'd0) begin errors++; $display("FAIL rst_fwd_e_rs: got %0d want 0", hif.fwd_e_rs); end
    checks++; if (hif.fwd_e_rt !== 2'd0) begin errors++; $display("FAIL rst_fwd_e_rt: got %0d want 0", hif.fwd_e_rt); end
    checks++; if (hif.fwd_m_rt !== 1'b0) begin errors++; $display("FAIL rst_fwd_m_rt: got %0b want 0", hif.fwd_m_rt); end
  endtask

  task automatic test_load_use();
    do_reset();
    drive(mk(9, 0, 8, 1, 3, 1, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_issue_stall: got %0b want 0", hif.stall); end
    step();
    drive(mk(8, 0, 0, 0, 0, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL lu_stall_e: got %0b want 1", hif.stall); end
    step();
    sample();
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL lu_stall_m: got %0b want 1", hif.stall); end
    step();
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", hif.stall); end
    checks++; if (hif.fwd_d_rs !== 2'd2) begin errors++; $display("FAIL lu_fwd_d_rs: got %0d want 2", hif.fwd_d_rs); end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    drive(mk(1, 2, 3, 1, 1, 0, 0, 0, 0));
    step();
    drive(mk(3, 0, 4, 1, 3, 0, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL alu_stall: got %0b want 0", hif.stall); end
    step();
    drive(nop());
    sample();
    checks++; if (hif.fwd_e_rs !== 2'd1) begin errors++; $display("FAIL alu_fwd_e_rs_m: got %0d want 1", hif.fwd_e_rs); end
    step();
    sample();
    checks++; if (hif.fwd_e_rs !== 2'd0) begin errors++; $display("FAIL alu_fwd_e_rs_done: got %0d want 0", hif.fwd_e_rs); end
  endtask

  task automatic test_jal_fwd();
    do_reset();
    drive(mk(0, 0, 31, 3, 3, 2, 0, 0, 0));
    step();
    drive(mk(31, 0, 0, 0, 3, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL jal_stall: got %0b want 0", hif.stall); end
    checks++; if (hif.fwd_d_rs !== 2'd3) begin errors++; $display("FAIL jal_fwd_d_rs: got %0d want 3", hif.fwd_d_rs); end
    do_reset();
    drive(mk(0, 0, 0, 3, 3, 2, 0, 0, 0));
    step();
    drive(mk(31, 0, 0, 0, 3, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL jal0_stall: got %0b want 0", hif.stall); end
    checks++; if (hif.fwd_d_rs !== 2'd0) begin errors++; $display("FAIL jal0_fwd_d_rs: got %0d want 0", hif.fwd_d_rs); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    drive(mk(9, 0, 5, 1, 3, 1, 0, 0, 0));
    step();
    drive(mk(6, 5, 0, 1, 2, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL b2b_sw1_stall: got %0b want 0", hif.stall); end
    step();
    drive(mk(7, 5, 0, 1, 2, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL b2b_sw2_stall: got %0b want 0", hif.stall); end
    checks++; if (hif.fwd_e_rt !== 2'd0) begin errors++; $display("FAIL b2b_fwd_e_rt_early: got %0d want 0", hif.fwd_e_rt); end
    step();
    drive(nop());
    sample();
    checks++; if (hif.fwd_m_rt !== 1'b1) begin errors++; $display("FAIL b2b_fwd_m_rt: got %0b want 1", hif.fwd_m_rt); end
    checks++; if (hif.fwd_e_rt !== 2'd2) begin errors++; $display("FAIL b2b_fwd_e_rt_w: got %0d want 2", hif.fwd_e_rt); end
  endtask

  task automatic test_md_busy();
    do_reset();
    drive(mk(1, 2, 0, 1, 1, 3, 1, 1, 1));
    sample();
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL md_idle: got %0b want 0", hif.md_busy); end
    step();
    drive(mk(0, 0, 7, 3, 3, 0, 0, 0, 1));
    for (int k = 0; k < DIV_N + 1; k++) begin
      sample();
      checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL md_busy_c%0d: got %0b want 1", k, hif.md_busy); end
      checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL md_stall_c%0d: got %0b want 1", k, hif.stall); end
      step();
    end
    sample();
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL md_busy_end: got %0b want 0", hif.md_busy); end
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL md_issue: got %0b want 0", hif.stall); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(mk(1, 2, 0, 1, 1, 3, 1, 1, 1));
    step();
    drive(mk(9, 0, 8, 1, 3, 1, 0, 0, 0));
    step();
    drive(mk(8, 0, 0, 0, 0, 3, 0, 0, 0));
    sample();
    checks++; if (hif.stall !== 1'b1) begin errors++; $display("FAIL mid_pre_stall: got %0b want 1", hif.stall); end
    checks++; if (hif.md_busy !== 1'b1) begin errors++; $display("FAIL mid_pre_busy: got %0b want 1", hif.md_busy); end
    reset = 1'b1;
    step();
    reset = 1'b0;
    sample();
    checks++; if (hif.stall !== 1'b0) begin errors++; $display("FAIL mid_stall: got %0b want 0", hif.stall); end
    checks++; if (hif.md_busy !== 1'b0) begin errors++; $display("FAIL mid_busy: got %0b want 0", hif.md_busy); end
    checks++; if ({hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt} !== 9'd0) begin
      errors++; $display("FAIL mid_fwd: got %b want 0", {hif.fwd_d_rs, hif.fwd_d_rt, hif.fwd_e_rs, hif.fwd_e_rt, hif.fwd_m_rt});
    end
  endtask

  function automatic instr_t rand_instr();
    instr_t d;
    int     t;
    d.ra1 = 5'($urandom_range(0, 3));
    d.ra2 = 5'($urandom_range(0, 3));
    d.wa  = 5'($urandom_range(0, 3));
    t = $urandom_range(0, 2);
    d.tuse_rs  = (t == 2) ? 2'd3 : 2'(t);
    d.tuse_rt  = 2'($urandom_range(0, 3));
    d.res      = 3'($urandom_range(0, 3));
    d.md_start = ($urandom_range(0, 9) == 0);
    d.md_div   = 1'($urandom_range(0, 1));
    d.md_use   = d.md_start | ($urandom_range(0, 7) == 0);
    return d;
  endfunction

  task automatic test_random();
    exp_t e;
    bit   held = 0;
    do_reset();
    for (int n = 0; n < 600; n++) begin
      if (!held) drive(rand_instr());
      sample();
      e = eval(cur);
      checks++; if (hif.stall !== e.stall) begin errors++; $display("FAIL rnd_stall n=%0d: got %0b want %0b", n, hif.stall, e.stall); end
      checks++; if (hif.md_busy !== e.md_busy) begin errors++; $display("FAIL rnd_md_busy n=%0d: got %0b want %0b", n, hif.md_busy, e.md_busy); end
      checks++; if (hif.fwd_d_rs !== e.fwd_d_rs) begin errors++; $display("FAIL rnd_fwd_d_rs n=%0d: got %0d want %0d", n, hif.fwd_d_rs, e.fwd_d_rs); end
      checks++; if (hif.fwd_d_rt !== e.fwd_d_rt) begin errors++; $display("FAIL rnd_fwd_d_rt n=%0d: got %0d want %0d", n, hif.fwd_d_rt, e.fwd_d_rt); end
      checks++; if (hif.fwd_e_rs !== e.fwd_e_rs) begin errors++; $display("FAIL rnd_fwd_e_rs n=%0d: got %0d want %0d", n, hif.fwd_e_rs, e.fwd_e_rs); end
      checks++; if (hif.fwd_e_rt !== e.fwd_e_rt) begin errors++; $display("FAIL rnd_fwd_e_rt n=%0d: got %0d want %0d", n, hif.fwd_e_rt, e.fwd_e_rt); end
      checks++; if (hif.fwd_m_rt !== e.fwd_m_rt) begin errors++; $display("FAIL rnd_fwd_m_rt n=%0d: got %0b want %0b", n, hif.fwd_m_rt, e.fwd_m_rt); end
      held = e.stall;
      if ($urandom_range(0, 149) == 0) begin
        reset = 1'b1;
        held  = 0;
      end
      step();
      reset = 1'b0;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    model_clear();
    drive(nop());
    test_reset();
    test_load_use();
    test_alu_fwd();
    test_jal_fwd();
    test_back_to_back();
    test_md_busy();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
